hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. It drives the flush and stall controls for the IF/ID and ID/EX pipeline registers, and produces the EX-stage operand-forwarding selects from the register fields those pipeline registers carry. Load-use stalls are sequenced by a small FSM with a configurable stall length, so a multi-cycle data memory can be added without touching the datapath.

## Interface
Parameters:
- LOAD_STALL_CYCLES, default 1: bubbles inserted per load-use hazard; legal range 1..15.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- EX_rs1, EX_rs2  in  5 each  source registers of the instruction in EX.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_result_src  in  1  1 = EX instruction is a load.
- EX_reg_write  in  1  EX instruction writes rd.
- EX_pc_src  in  1  branch or jump taken, resolved in EX.
- MEM_rd, WB_rd  in  5 each  destination registers in MEM and WB.
- MEM_reg_write, WB_reg_write  in  1 each  write enables for MEM and WB.
- IF_stall, ID_stall  out  1 each  hold the PC and the IF/ID register.
- IF_ID_flush, ID_EX_flush  out  1 each  clear the pipeline register on the next edge.
- EX_forward_a, EX_forward_b  out  2 each  operand source select: 00 register file, 01 WB result, 10 MEM ALU result.
- perf_stall_cnt, perf_flush_cnt  out  32 each  present only with HAZARD_PERF_EN.

## Operation
FSM states: RUN and STALL. A down-counter `cnt` is 4 bits wide.

- `load_use` = EX_result_src & EX_reg_write & (EX_rd != 0) & (EX_rd == ID_rs1 | EX_rd == ID_rs2).

In RUN:
- If EX_pc_src = 1 (highest priority): IF_ID_flush = 1, ID_EX_flush = 1, stalls = 0. The FSM stays in RUN.
- Else if load_use: IF_stall = 1, ID_stall = 1, ID_EX_flush = 1.
  - If LOAD_STALL_CYCLES > 1, go to STALL with cnt = LOAD_STALL_CYCLES - 1.
  - Otherwise stay in RUN.
- Else all controls are 0.

In STALL:
- IF_stall = 1, ID_stall = 1, ID_EX_flush = 1, and cnt decrements each cycle.
- When cnt == 1, return to RUN on the next edge.
- load_use is not re-evaluated in STALL.
- If EX_pc_src = 1 in STALL: flush wins. Drive IF_ID_flush = 1 and ID_EX_flush = 1, stalls = 0, and go to RUN with cnt = 0.

Forwarding is combinational and state-independent. EX_forward_a is derived as follows (EX_forward_b is identical using EX_rs2):
- 10 if MEM_reg_write & MEM_rd != 0 & MEM_rd == EX_rs1.
- Else 01 if WB_reg_write & WB_rd != 0 & WB_rd == EX_rs1.
- Else 00.
- When MEM and WB both match, MEM wins because it is the newest value.

Other boundary rules:
- Register x0 never triggers a hazard or forwarding.
- A load whose rd matches both ID_rs1 and ID_rs2 produces one stall sequence, not two.

## Timing
- All flush, stall and forward outputs are combinational from the inputs and the current state. They are valid in the same cycle and take effect at the next rising edge of clk.
- Load-use penalty: exactly LOAD_STALL_CYCLES cycles with IF_stall high.
- Taken-branch penalty: 2 bubbles (the instructions in IF/ID and ID/EX are squashed).
- Reset values:
  - State = RUN, cnt = 0, perf counters = 0.
  - While reset is high, all stall and flush outputs are 0. Forward selects still follow the inputs.
- Reset asserted mid-STALL aborts the sequence immediately. The first cycle after release is RUN.

## Configuration
Macro HAZARD_PERF_EN.

Defined:
- perf_stall_cnt increments on every cycle with IF_stall = 1.
- perf_flush_cnt increments on every cycle with IF_ID_flush = 1.
- Both are 32-bit and wrap from 0xFFFFFFFF to 0.

Undefined:
- The perf ports and their registers do not exist.
- Hazard behaviour is identical in both builds.

## Structure
- The shared package hazard_pkg holds:
  - the state enum {RUN, STALL};
  - localparams FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- The datapath EX-stage operand mux imports the same FWD_* constants.
- One sub-module, forward_sel, is instantiated twice (operand A and operand B). It is purely combinational, with inputs rs, MEM_rd, MEM_reg_write, WB_rd, WB_reg_write and a 2-bit select output.
- The FSM, counter and perf counters live in hazard_unit.

## Test plan
- **Load-use hazard:** EX_result_src = 1, EX_reg_write = 1, EX_rd = 5, ID_rs2 = 5, LOAD_STALL_CYCLES = 1 → IF_stall, ID_stall and ID_EX_flush high for exactly 1 cycle, then all 0.
- **Multi-cycle stall:** same stimulus with LOAD_STALL_CYCLES = 3 → stall high for 3 consecutive cycles. Inputs changing during STALL do not extend it.
- **Branch beats load-use:** EX_pc_src = 1 together with a load-use condition → IF_ID_flush = ID_EX_flush = 1, stalls = 0, state stays RUN.
- **Forwarding priority:**
  - MEM_rd = WB_rd = EX_rs1 = 7 with both write enables set → EX_forward_a = 10.
  - Then MEM_reg_write = 0 → EX_forward_a = 01.
  - With EX_rs1 = 0 → EX_forward_a = 00.
- **Reset mid-sequence:** assert reset in the 2nd cycle of a 3-cycle stall → outputs 0 immediately. After release, no stall unless load_use is present.
- **Perf counters (HAZARD_PERF_EN):** 3 stall cycles plus 1 taken branch → perf_stall_cnt = 3, perf_flush_cnt = 1. Preload 0xFFFFFFFF and stall once → perf_stall_cnt = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard unit.
//   - hazard_state_e : load-use sequencer states {RUN, STALL}
//   - FWD_*          : EX-stage operand select encodings, also imported by the datapath operand mux
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } hazard_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
  localparam logic [1:0] FWD_WB  = 2'b01;  // WB-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage ALU result

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline register fields into the hazard unit and controls back out.
//   master : pipeline side, drives register fields / write enables / pc_src, receives controls
//   slave  : hazard unit side
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_if;

  logic [4:0] ID_rs1;
  logic [4:0] ID_rs2;
  logic [4:0] EX_rs1;
  logic [4:0] EX_rs2;
  logic [4:0] EX_rd;
  logic       EX_result_src;
  logic       EX_reg_write;
  logic       EX_pc_src;
  logic [4:0] MEM_rd;
  logic [4:0] WB_rd;
  logic       MEM_reg_write;
  logic       WB_reg_write;

  logic       IF_stall;
  logic       ID_stall;
  logic       IF_ID_flush;
  logic       ID_EX_flush;
  logic [1:0] EX_forward_a;
  logic [1:0] EX_forward_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  modport master (
    output ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, EX_result_src, EX_reg_write, EX_pc_src,
    output MEM_rd, WB_rd, MEM_reg_write, WB_reg_write,
    input  IF_stall, ID_stall, IF_ID_flush, ID_EX_flush, EX_forward_a, EX_forward_b
`ifdef HAZARD_PERF_EN
    ,
    input  perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, EX_result_src, EX_reg_write, EX_pc_src,
    input  MEM_rd, WB_rd, MEM_reg_write, WB_reg_write,
    output IF_stall, ID_stall, IF_ID_flush, ID_EX_flush, EX_forward_a, EX_forward_b
`ifdef HAZARD_PERF_EN
    ,
    output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/forward_sel.sv
// forward_sel: combinational EX operand source select for one source register.
//   rs            : source register of the EX instruction
//   MEM_rd/WB_rd  : destination registers in MEM and WB, with their write enables
//   sel           : FWD_MEM, FWD_WB or FWD_RF
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] MEM_rd,
  input  logic       MEM_reg_write,
  input  logic [4:0] WB_rd,
  input  logic       WB_reg_write,
  output logic [1:0] sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is hardwired to zero, so it is never a forwarding source.
  assign w_mem_hit = MEM_reg_write && (MEM_rd != 5'd0) && (MEM_rd == rs);
  assign w_wb_hit  = WB_reg_write && (WB_rd != 5'd0) && (WB_rd == rs);

  // MEM holds the younger write, so it takes precedence over WB.
  always_comb begin
    sel = FWD_RF;
    if (w_mem_hit) begin
      sel = FWD_MEM;
    end else if (w_wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: flush/stall control for IF/ID and ID/EX plus EX operand forwarding selects.
//   clk, reset : core clock, asynchronous active-high reset
//   hz (slave) : register fields, write enables and pc_src in; stall, flush, forward selects out
// Parameter LOAD_STALL_CYCLES (1..15): bubbles inserted per load-use hazard.
// Optional macro HAZARD_PERF_EN adds 32-bit wrapping stall-cycle and flush-cycle counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic    clk,
  input  logic    reset,
  hazard_unit_if.slave hz
);

  if ((LOAD_STALL_CYCLES < 1) || (LOAD_STALL_CYCLES > 15)) begin : g_param_check
    $error("LOAD_STALL_CYCLES must be within 1..15");
  end

  // The first stall cycle is spent in RUN, so STALL covers the remaining ones.
  localparam logic [3:0] StallInit = 4'(LOAD_STALL_CYCLES - 1);

  hazard_state_e r_state;
  logic [3:0]    r_cnt;
  logic          w_load_use;

  assign w_load_use = hz.EX_result_src && hz.EX_reg_write && (hz.EX_rd != 5'd0) &&
                      ((hz.EX_rd == hz.ID_rs1) || (hz.EX_rd == hz.ID_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (!hz.EX_pc_src && w_load_use && (LOAD_STALL_CYCLES > 1)) begin
            r_state <= STALL;
            r_cnt   <= StallInit;
          end
        end
        STALL: begin
          // A taken branch squashes the stalled instructions, so the sequence is moot.
          if (hz.EX_pc_src) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= RUN;
            end
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  logic w_if_stall;
  logic w_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;

  always_comb begin
    w_if_stall    = 1'b0;
    w_id_stall    = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (!reset) begin
      if (hz.EX_pc_src) begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if ((r_state == STALL) || w_load_use) begin
        w_if_stall    = 1'b1;
        w_id_stall    = 1'b1;
        w_id_ex_flush = 1'b1;
      end
    end
  end

  assign hz.IF_stall    = w_if_stall;
  assign hz.ID_stall    = w_id_stall;
  assign hz.IF_ID_flush = w_if_id_flush;
  assign hz.ID_EX_flush = w_id_ex_flush;

  forward_sel u_fwd_a (
    .rs            (hz.EX_rs1),
    .MEM_rd        (hz.MEM_rd),
    .MEM_reg_write (hz.MEM_reg_write),
    .WB_rd         (hz.WB_rd),
    .WB_reg_write  (hz.WB_reg_write),
    .sel           (hz.EX_forward_a)
  );

  forward_sel u_fwd_b (
    .rs            (hz.EX_rs2),
    .MEM_rd        (hz.MEM_rd),
    .MEM_reg_write (hz.MEM_reg_write),
    .WB_rd         (hz.WB_rd),
    .WB_reg_write  (hz.WB_reg_write),
    .sel           (hz.EX_forward_b)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall_cnt <= 32'd0;
      r_perf_flush_cnt <= 32'd0;
    end else begin
      if (w_if_stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (w_if_id_flush) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cnt = r_perf_stall_cnt;
  assign hz.perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
